// File: rtl/adder_pkg.sv
// Configuration helpers shared by the pipelined carry-select adder.
// Segment width derivation and the WIDTH/STAGES legality check live here.
package adder_pkg;

    function automatic int unsigned seg_width(input int unsigned width,
                                              input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    function automatic bit cfg_legal(input int unsigned width, input int unsigned stages);
        return (stages != 0) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/carryselect_segment.sv
// One carry-select segment: both candidate sums are formed up front and the
// late-arriving carry only drives the final mux.
module carryselect_segment #(
    parameter int unsigned SEG_W = 16
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout
);

    logic [SEG_W:0] sum0;
    logic [SEG_W:0] sum1;

    always_comb begin
        sum0        = {1'b0, a} + {1'b0, b};
        sum1        = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, 1'b1};
        {cout, s}   = cin ? sum1 : sum0;
    end

endmodule

// File: rtl/pipelined_carryselect_adder.sv
// Pipelined add/subtract unit: one carry-select segment resolved per stage,
// valid/ready handshake with per-stage backpressure.
module pipelined_carryselect_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned SegW = seg_width(WIDTH, STAGES);
    localparam int          Last = int'(STAGES) - 1;

    if (!cfg_legal(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_carryselect_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    // Stage k register holds operands (B already inverted), completed low segments,
    // and the carry out of segment k.
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0]            c_q, v_q;
    logic                         ovf_q;

    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_d;
    logic [STAGES-1:0]            c_in, v_in;
    logic [STAGES-1:0][SegW-1:0]  seg_s;
    logic [STAGES-1:0]            seg_c;
    logic [STAGES-1:0]            adv;
    logic                         ovf_d;

    always_comb begin
        a_in[0] = A;
        b_in[0] = Sub ? ~B : B;
        c_in[0] = Sub | Cin;
        s_in[0] = '0;
        v_in[0] = in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_seg
        carryselect_segment #(
            .SEG_W(SegW)
        ) u_seg (
            .a   (a_in[k][k*SegW +: SegW]),
            .b   (b_in[k][k*SegW +: SegW]),
            .cin (c_in[k]),
            .s   (seg_s[k]),
            .cout(seg_c[k])
        );
    end

    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            s_d[k]                   = s_in[k];
            s_d[k][k*SegW +: SegW]   = seg_s[k];
        end
        ovf_d = (a_in[Last][WIDTH-1] == b_in[Last][WIDTH-1]) &&
                (seg_s[Last][SegW-1] != a_in[Last][WIDTH-1]);
    end

    // Walk back from the output: a stage moves when it is empty or its successor moves.
    always_comb begin
        logic go;
        go  = out_ready;
        adv = '0;
        for (int k = Last; k >= 0; k--) begin
            go     = !v_q[k] || go;
            adv[k] = go;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_in[k];
                    if (v_in[k]) begin
                        a_q[k] <= a_in[k];
                        b_q[k] <= b_in[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= seg_c[k];
                    end
                end
            end
            if (adv[Last] && v_in[Last]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    // Last-stage operand copies only exist to keep the register array regular.
    logic unused_last_ops;
    assign unused_last_ops = ^{a_q[Last], b_q[Last]};

    assign in_ready  = adv[0];
    assign out_valid = v_q[Last];
    assign S         = s_q[Last];
    assign Cout      = c_q[Last];
    assign Ovf       = ovf_q;

endmodule
